// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRP_DEF   = 2;
endpackage

// File: rtl/rf_clear_ctrl.sv
// Post-reset clear sequencer: sweeps every register to zero, then enters RUN and raises ready.
module rf_clear_ctrl
  import reg_file_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        // Leave CLEAR on the same edge that zeroes the last register.
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign clr_en   = (state_q == CLEAR);
  assign clr_addr = cnt_q;
  assign ready    = (state_q == RUN);
endmodule

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with zero register and post-reset clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle committing writes to matching read lanes.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRP   = NRP_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  output logic                ready
);
  localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

  // Register 0 is hard-wired to zero and addresses past the array hold nothing.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_W);
  endfunction

  logic            clr_en;
  logic [AW-1:0]   clr_addr;
  logic            wr0, wr1;
  logic [XLEN-1:0] regs [NREGS];

  rf_clear_ctrl #(.NREGS(NREGS)) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  assign wr0 = we0 && ready && addr_ok(wa0);
  assign wr1 = we1 && ready && addr_ok(wa1);

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clr_en) regs[clr_addr] <= '0;
    if (wr0)    regs[wa0]      <= wd0;
    if (wr1)    regs[wa1]      <= wd1;
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;

    assign a = raddr[i*AW +: AW];

    always_comb begin
      d = '0;
      if (ready && addr_ok(a)) d = regs[a];
`ifdef REGFILE_BYPASS_EN
      if (wr0 && (wa0 == a)) d = wd0;
      if (wr1 && (wa1 == a)) d = wd1;
`endif
    end

    assign rdata[i*XLEN +: XLEN] = d;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized scoreboard bench for reg_file_mp against an array-based reference model.
module tb_reg_file_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRP   = 2;
  localparam int AW    = $clog2(NREGS);

  logic                clk;
  logic                rst_n;
  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic                we0, we1;
  logic [AW-1:0]       wa0, wa1;
  logic [XLEN-1:0]     wd0, wd1;
  logic                ready;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (raddr),
    .rdata (rdata),
    .we0   (we0),
    .wa0   (wa0),
    .wd0   (wd0),
    .we1   (we1),
    .wa1   (wa1),
    .wd1   (wd1),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string               tag;
    logic                rdy;
    logic [NRP*XLEN-1:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: register values plus number of clean edges since reset release.
  logic [XLEN-1:0] mem [NREGS];
  int              swept = 0;

  function automatic logic m_ready();
    return swept >= NREGS;
  endfunction

  function automatic logic [XLEN-1:0] m_read(input int a);
    logic [XLEN-1:0] v;
    if (!m_ready() || a == 0 || a >= NREGS) return '0;
    v = mem[a];
`ifdef REGFILE_BYPASS_EN
    if (we0 && int'(wa0) == a) v = wd0;
    if (we1 && int'(wa1) == a) v = wd1;
`endif
    return v;
  endfunction

  task automatic m_edge();
    if (!rst_n) begin
      swept = 0;
      for (int r = 0; r < NREGS; r++) mem[r] = '0;
    end else if (swept < NREGS) begin
      swept++;
    end else begin
      if (we0 && wa0 != 0) mem[wa0] = wd0;
      if (we1 && wa1 != 0) mem[wa1] = wd1;
    end
  endtask

  // Inputs are stable here; record what the DUT must show this cycle, then advance one edge.
  task automatic step(input string tag);
    exp_t e;
    e.tag = tag;
    e.rdy = m_ready();
    e.rd  = '0;
    for (int l = 0; l < NRP; l++)
      e.rd[l*XLEN +: XLEN] = m_read(int'(raddr[l*AW +: AW]));
    exp_q.push_back(e);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0;
    we1 = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    raddr[0 +: AW]  = AW'(a0);
    raddr[AW +: AW] = AW'(a1);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (ready !== mon_e.rdy) begin
        errors++;
        $display("FAIL %s ready got=%0b exp=%0b t=%0t", mon_e.tag, ready, mon_e.rdy, $time);
      end
      for (int l = 0; l < NRP; l++) begin
        checks++;
        if (rdata[l*XLEN +: XLEN] !== mon_e.rd[l*XLEN +: XLEN]) begin
          errors++;
          $display("FAIL %s lane%0d rdata got=%h exp=%h t=%0t", mon_e.tag, l,
                   rdata[l*XLEN +: XLEN], mon_e.rd[l*XLEN +: XLEN], $time);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    raddr = '0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    for (int r = 0; r < NREGS; r++) mem[r] = '0;
    @(posedge clk);
    #1;
    repeat (2) step("reset");

    // Release reset; a write during the sweep must be ignored.
    rst_n = 1'b1;
    set_rd(5, 1);
    we0 = 1'b1; wa0 = AW'(5); wd0 = 32'hCAFEF00D;
    step("clear_write");
    idle();
    repeat (NREGS - 1) step("sweep");

    for (int r = 0; r < NREGS; r += 2) begin
      set_rd(r, r + 1);
      step("all_zero");
    end

    // Single write, visible the cycle after commit, held after we0 drops.
    set_rd(0, 20);
    we0 = 1'b1; wa0 = AW'(20); wd0 = 32'h12345678;
    step("w20_commit");
    idle();
    step("w20_read");
    step("w20_hold");

    // Same-address collision: port 1 wins.
    we0 = 1'b1; wa0 = AW'(18); wd0 = 32'hAAAA0000;
    we1 = 1'b1; wa1 = AW'(18); wd1 = 32'h87654321;
    set_rd(18, 20);
    step("collide_commit");
    idle();
    step("collide_read");

    // Register 0 ignores writes; write during clear left reg 5 at zero.
    we0 = 1'b1; wa0 = '0; wd0 = 32'hFFFFFFFF;
    set_rd(0, 0);
    step("r0_write");
    idle();
    set_rd(0, 5);
    step("r0_read");

    // Same-cycle read of a register being written.
    we1 = 1'b1; wa1 = AW'(11); wd1 = 32'h11111111;
    step("w11_old");
    idle();
    we0 = 1'b1; wa0 = AW'(11); wd0 = 32'hDEADBEEF;
    set_rd(11, 18);
    step("bypass");
    idle();
    step("bypass_after");

    // One-cycle reset pulse in RUN restarts the sweep and wipes earlier writes.
    rst_n = 1'b0;
    step("rerst");
    rst_n = 1'b1;
    set_rd(20, 18);
    repeat (NREGS) step("resweep");
    step("post_resweep");
    set_rd(11, 5);
    step("post_resweep2");

    // Randomized traffic with occasional reset pulses and biased address collisions.
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      we0   = $urandom_range(0, 1);
      we1   = $urandom_range(0, 1);
      wa0   = AW'($urandom_range(0, 7));
      wa1   = ($urandom_range(0, 2) == 0) ? wa0 : AW'($urandom_range(0, NREGS - 1));
      wd0   = $urandom;
      wd1   = $urandom;
      if ($urandom_range(0, 1) == 1) set_rd(int'(wa0), int'(wa1));
      else set_rd($urandom_range(0, 7), $urandom_range(0, NREGS - 1));
      step("random");
    end

    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count (2..64); AW = clog2(NREGS), derived, not overridable.
REQ-003 Parameter NRP, default 2, read-port count (1..4).
REQ-004 Port clk  in  1  rising-edge clock, the only clock.
REQ-005 Port rst_n  in  1  synchronous, active-low reset.
REQ-006 Port raddr  in  NRP*AW  packed read addresses; port i occupies bits [i*AW +: AW].
REQ-007 Port rdata  out  NRP*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
REQ-008 Port we0 / wa0 / wd0  in  1 / AW / XLEN  write port 0: enable, address, data.
REQ-009 Port we1 / wa1 / wd1  in  1 / AW / XLEN  write port 1: enable, address, data.
REQ-010 Port ready  out  1  high when the register file is in RUN and accepts writes.

Function
REQ-011 The block SHALL have two states: CLEAR and RUN.
REQ-012 In CLEAR, one register per cycle SHALL be zeroed, with a sweep counter stepping 0..NREGS-1.
REQ-013 The transition CLEAR->RUN SHALL occur on the edge that clears register NREGS-1; total sweep length is NREGS cycles after rst_n rises.
REQ-014 In CLEAR, ready SHALL be 0, we0/we1 SHALL be ignored, and every rdata lane SHALL read 0.
REQ-015 In RUN, ready SHALL be 1 and RUN SHALL hold until rst_n is low.
REQ-016 A write SHALL commit on the rising clk edge when its we is high, ready is 1 and its address is non-zero and below NREGS.
REQ-017 Register 0 SHALL always read 0, and writes to it SHALL be dropped silently.
REQ-018 A read address of NREGS or higher SHALL return 0, and a write to such an address SHALL be dropped.
REQ-019 When we0 and we1 both target the same address in one cycle, port 1 data SHALL be stored.
REQ-020 Reads SHALL be combinational from the array; without bypass, written data SHALL become visible on the cycle after the commit edge.
REQ-021 Read ports SHALL be independent; any number of ports may read the same address in one cycle.

Reset
REQ-022 While rst_n is low at a clk edge: state SHALL be CLEAR, the sweep counter SHALL be 0 and ready SHALL be 0; array contents are don't-care until swept.
REQ-023 Asserting rst_n during RUN or mid-sweep SHALL restart the full sweep from register 0.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN SHALL control write-to-read bypass.
REQ-025 With REGFILE_BYPASS_EN defined, a read lane whose address matches an enabled, committing write in the same cycle SHALL return that write's data combinationally, with port 1 taking priority.
REQ-026 Bypass SHALL not apply to address 0, to out-of-range addresses or in CLEAR.
REQ-027 Without REGFILE_BYPASS_EN, there SHALL be no forwarding, and the REQ-020 timing applies.

Structure
REQ-028 Package reg_file_pkg SHALL hold the state enum (CLEAR, RUN) and the default XLEN/NREGS/NRP constants.
REQ-029 Sub-module rf_clear_ctrl SHALL own the state machine, the sweep counter and ready, and SHALL output a clear-enable and a clear-address to the array.

Verification
REQ-030 Reset release with NREGS=32 -> ready=0 for exactly 32 cycles and then 1; all registers read 0 at the first ready cycle.
REQ-031 RUN: we0=1, wa0=20, wd0=32'h12345678; next cycle raddr lane1=20 -> rdata lane1=32'h12345678, which holds after we0 drops.
REQ-032 Same cycle: we0 to address 18 with 32'hAAAA0000 and we1 to address 18 with 32'h87654321 -> the next read of 18 returns 32'h87654321.
REQ-033 Write 32'hFFFFFFFF to address 0 -> the read of address 0 returns 0; during CLEAR, a write to address 5 -> address 5 reads 0 after the sweep.
REQ-034 With REGFILE_BYPASS_EN defined, writing 32'hDEADBEEF to address 11 while lane0 reads 11 -> lane0=32'hDEADBEEF in the same cycle; without the macro -> the old value is returned that cycle.
REQ-035 rst_n pulsed low for 1 cycle in RUN after writes -> ready drops, the sweep repeats, and the previously written registers read 0.
